stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 275 +++++++++++++++++++++++++++
 tb/tb_stream_demux.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux (with local FIFO sub-module stream_demux_fifo)
//  Description : Packet-aware 1-to-2 stream demultiplexer. The destination of
//                each packet is taken from in_sel on its first beat and held
//                until the beat carrying in_last has been accepted. Each
//                output is buffered by a first-word-fall-through FIFO, so a
//                stall on one output never prevents the other from draining.
//  Ports       : clk, rst            - rising-edge clock, sync active-high reset
//                in_valid/in_ready   - upstream handshake
//                in_data/in_last     - upstream payload and end-of-packet flag
//                in_sel              - destination, sampled on first beat only
//                outX_valid/ready    - downstream handshake, X in {0,1}
//                outX_data/last      - downstream payload and end-of-packet
//                pkt_cnt0/pkt_cnt1   - wrapping count of packets completed
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  stream_demux_fifo
//  First-word-fall-through FIFO. The head entry is presented combinationally
//  whenever the FIFO is non-empty; pop_data is forced to zero when empty.
//  Pointers carry one extra wrap bit so full and empty are distinguishable
//  without a separate occupancy counter.
// ----------------------------------------------------------------------------
module stream_demux_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;

    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    // Equal pointers: empty. Same index but opposite wrap bit: full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

    // Guard against writing a full FIFO or reading an empty one even if the
    // caller misbehaves; normal operation never relies on this.
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop  && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= push_data;
        end
    end

    assign pop_data = w_empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// ----------------------------------------------------------------------------
//  stream_demux (top)
//  DEPTH must be a power of two and at least 2.
// ----------------------------------------------------------------------------
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_sel,

    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_last,

    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_last,

    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1
);

    // Each FIFO entry stores {last, data}.
    localparam int c_ENTRY_W = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE0 = 2'd1,
        ST_ROUTE1 = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 w_target;
    logic                 w_target_full;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_push0;
    logic                 w_push1;
    logic                 w_pop0;
    logic                 w_pop1;

    logic [c_ENTRY_W-1:0] w_entry_in;
    logic [c_ENTRY_W-1:0] w_head0;
    logic [c_ENTRY_W-1:0] w_head1;
    logic                 w_full0;
    logic                 w_full1;
    logic                 w_empty0;
    logic                 w_empty1;

    logic [15:0]          r_pkt_cnt0;
    logic [15:0]          r_pkt_cnt1;

    // ------------------------------------------------------------------
    // Routing: in_sel only matters between packets. Once a multi-beat
    // packet has started, the route is locked by the FSM state.
    // ------------------------------------------------------------------
    always_comb begin
        w_target = in_sel;
        case (r_state)
            ST_ROUTE0: w_target = 1'b0;
            ST_ROUTE1: w_target = 1'b1;
            default:   w_target = in_sel;
        endcase
    end

    // Backpressure depends only on the FIFO currently targeted, so a stalled
    // output blocks the input only while it is the destination.
    assign w_target_full = w_target ? w_full1 : w_full0;
    assign w_in_ready    = !rst && !w_target_full;
    assign w_accept      = in_valid && w_in_ready;

    assign w_push0    = w_accept && !w_target;
    assign w_push1    = w_accept &&  w_target;
    assign w_entry_in = {in_last, in_data};

    assign w_pop0 = !w_empty0 && out0_ready;
    assign w_pop1 = !w_empty1 && out1_ready;

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // A first beat without last opens a packet on its target;
                // a first beat with last is a complete single-beat packet.
                if (w_accept && !in_last) begin
                    w_state_next = in_sel ? ST_ROUTE1 : ST_ROUTE0;
                end
            end
            ST_ROUTE0, ST_ROUTE1: begin
                if (w_accept && in_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Completed-packet counters (wrap naturally at 16 bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (w_push0 && in_last) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
            end
            if (w_push1 && in_last) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffers
    // ------------------------------------------------------------------
    stream_demux_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push0),
        .push_data (w_entry_in),
        .pop       (w_pop0),
        .pop_data  (w_head0),
        .full      (w_full0),
        .empty     (w_empty0)
    );

    stream_demux_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push1),
        .push_data (w_entry_in),
        .pop       (w_pop1),
        .pop_data  (w_head1),
        .full      (w_full1),
        .empty     (w_empty1)
    );

    // ------------------------------------------------------------------
    // Outputs (FIFO heads are already zero when empty)
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;

    assign out0_valid = !w_empty0;
    assign out0_data  = w_head0[DATA_W-1:0];
    assign out0_last  = w_head0[DATA_W];

    assign out1_valid = !w_empty1;
    assign out1_data  = w_head1[DATA_W-1:0];
    assign out1_last  = w_head1[DATA_W];

    assign pkt_cnt0   = r_pkt_cnt0;
    assign pkt_cnt1   = r_pkt_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux
//  Description : Self-checking bench for stream_demux. Expected beats are
//                queued per output as they are offered and compared when the
//                DUT hands them over downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_sel;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_last;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_last;
    logic [15:0]       pkt_cnt0;
    logic [15:0]       pkt_cnt1;

    int errors = 0;
    int checks = 0;

    logic [DATA_W:0] exp0[$];
    logic [DATA_W:0] exp1[$];

    stream_demux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: inputs change only just after rising edges, so the
    // values seen on the falling edge are those the next rising edge uses.
    always @(negedge clk) begin : mon
        logic [DATA_W:0] e;
        if (!rst) begin
            if (out0_valid && out0_ready) begin
                checks++;
                if (exp0.size() == 0) begin
                    errors++;
                    $display("FAIL out0_unexpected: got last=%b data=%h, required no beat", out0_last, out0_data);
                end else begin
                    e = exp0.pop_front();
                    if ({out0_last, out0_data} !== e) begin
                        errors++;
                        $display("FAIL out0_beat: got %h, required %h", {out0_last, out0_data}, e);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_unexpected: got last=%b data=%h, required no beat", out1_last, out1_data);
                end else begin
                    e = exp1.pop_front();
                    if ({out1_last, out1_data} !== e) begin
                        errors++;
                        $display("FAIL out1_beat: got %h, required %h", {out1_last, out1_data}, e);
                    end
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one beat and hold it until accepted. Called just after a rising
    // edge; returns just after the accepting edge. waited = extra cycles.
    task automatic send_beat(input logic dest, input logic sel, input logic [DATA_W-1:0] d,
                             input logic last, output int waited);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else if (dest) begin
            exp1.push_back({last, d});
        end else begin
            exp0.push_back({last, d});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input bit incl0);
        int n = 0;
        while (((incl0 && exp0.size() != 0) || exp1.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if ((incl0 && exp0.size() != 0) || exp1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending out0=%0d out1=%0d, required 0", name, exp0.size(), exp1.size());
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_during_rst: got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        checks++;
        if ({out0_valid, out0_last, out0_data} !== '0) begin
            errors++; $display("FAIL reset_out0: got %b/%b/%h, required 0/0/00", out0_valid, out0_last, out0_data);
        end
        checks++;
        if ({out1_valid, out1_last, out1_data} !== '0) begin
            errors++; $display("FAIL reset_out1: got %b/%b/%h, required 0/0/00", out1_valid, out1_last, out1_data);
        end
        checks++;
        if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0) begin
            errors++; $display("FAIL reset_counts: got %h/%h, required 0000/0000", pkt_cnt0, pkt_cnt1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        int w;
        out0_ready = 1'b1; out1_ready = 1'b1;
        send_beat(1'b1, 1'b1, 8'hA5, 1'b1, w);
        checks++;
        if ({out1_valid, out1_last, out1_data} !== 10'h3A5) begin
            errors++; $display("FAIL single_out1: got %b/%b/%h, required 1/1/a5", out1_valid, out1_last, out1_data);
        end
        checks++;
        if (out0_valid !== 1'b0) begin
            errors++; $display("FAIL single_out0_valid: got %b, required 0", out0_valid);
        end
        checks++;
        if (pkt_cnt1 !== 16'd1) begin
            errors++; $display("FAIL single_pkt_cnt1: got %0d, required 1", pkt_cnt1);
        end
        wait_drain("single", 1'b1);
        checks++;
        if (out1_valid !== 1'b0) begin
            errors++; $display("FAIL single_out1_empty: got %b, required 0", out1_valid);
        end
    endtask

    task automatic test_multi_beat();
        int w;
        out0_ready = 1'b1; out1_ready = 1'b1;
        send_beat(1'b0, 1'b0, 8'h11, 1'b0, w);
        send_beat(1'b0, 1'b1, 8'h22, 1'b0, w);
        send_beat(1'b0, 1'b0, 8'h33, 1'b1, w);
        wait_drain("multi", 1'b1);
        checks++;
        if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
            errors++; $display("FAIL multi_counts: got %0d/%0d, required 1/1", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_backpressure();
        int w;
        out0_ready = 1'b0; out1_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(1'b0, 1'b0, 8'h40 + 8'(i), 1'b0, w);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out0_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: in_ready=%b out0_valid=%b, required 0/1", in_ready, out0_valid);
        end
        out0_ready = 1'b1;
        @(posedge clk);
        #1;
        out0_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_reassert: in_ready=%b, required 1", in_ready);
        end
        send_beat(1'b0, 1'b0, 8'h44, 1'b0, w);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_refull: in_ready=%b, required 0", in_ready);
        end
        out0_ready = 1'b1;
        send_beat(1'b0, 1'b1, 8'h45, 1'b1, w);
        wait_drain("bp", 1'b1);
        checks++;
        if (pkt_cnt0 !== 16'd2) begin
            errors++; $display("FAIL bp_pkt_cnt0: got %0d, required 2", pkt_cnt0);
        end
    endtask

    task automatic test_independence();
        int w;
        out0_ready = 1'b0; out1_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(1'b0, 1'b0, 8'h50 + 8'(i), 1'b1, w);
        end
        in_sel = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL indep_blocked: in_ready=%b, required 0", in_ready);
        end
        in_sel = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL indep_open: in_ready=%b, required 1", in_ready);
        end
        send_beat(1'b1, 1'b1, 8'h60, 1'b0, w);
        send_beat(1'b1, 1'b0, 8'h61, 1'b1, w);
        wait_drain("indep1", 1'b0);
        checks++;
        if (out1_valid !== 1'b0 || {out0_valid, out0_last, out0_data} !== 10'h350) begin
            errors++; $display("FAIL indep_state: out1_valid=%b out0=%b/%b/%h, required 0 and 1/1/50",
                               out1_valid, out0_valid, out0_last, out0_data);
        end
        out0_ready = 1'b1;
        wait_drain("indep0", 1'b1);
        checks++;
        if (pkt_cnt0 !== 16'd6 || pkt_cnt1 !== 16'd2) begin
            errors++; $display("FAIL indep_counts: got %0d/%0d, required 6/2", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_reset_mid_packet();
        int w;
        out0_ready = 1'b1; out1_ready = 1'b0;
        send_beat(1'b1, 1'b1, 8'h70, 1'b0, w);
        send_beat(1'b1, 1'b0, 8'h71, 1'b0, w);
        checks++;
        if (out1_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_buffered: out1_valid=%b, required 1", out1_valid);
        end
        pulse_reset();
        checks++;
        if (out1_valid !== 1'b0 || pkt_cnt1 !== 16'd0 || pkt_cnt0 !== 16'd0) begin
            errors++; $display("FAIL rstmid_cleared: out1_valid=%b cnt0=%0d cnt1=%0d, required 0/0/0",
                               out1_valid, pkt_cnt0, pkt_cnt1);
        end
        out1_ready = 1'b1;
        send_beat(1'b0, 1'b0, 8'h77, 1'b1, w);
        checks++;
        if (out0_valid !== 1'b1 || out1_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_route: out0_valid=%b out1_valid=%b, required 1/0", out0_valid, out1_valid);
        end
        wait_drain("rstmid", 1'b1);
        checks++;
        if (pkt_cnt0 !== 16'd1) begin
            errors++; $display("FAIL rstmid_pkt_cnt0: got %0d, required 1", pkt_cnt0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic dest;
        int nb;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            dest = 1'($urandom_range(0, 1));
            nb   = 1 + (p % 3);
            for (int b = 0; b < nb; b++) begin
                send_beat(dest, (b == 0) ? dest : 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)), (b == nb - 1), w);
                checks++;
                if (w !== 0) begin
                    errors++; $display("FAIL b2b_stall: packet %0d beat %0d waited %0d cycles, required 0", p, b, w);
                end
            end
        end
        wait_drain("b2b", 1'b1);
    endtask

    task automatic test_counter_wrap();
        int w;
        pulse_reset();
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            send_beat(1'b0, 1'b0, 8'(i), 1'b1, w);
        end
        checks++;
        if (pkt_cnt0 !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max: pkt_cnt0=%h, required ffff", pkt_cnt0);
        end
        send_beat(1'b0, 1'b0, 8'hFF, 1'b1, w);
        checks++;
        if (pkt_cnt0 !== 16'h0000 || pkt_cnt1 !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: pkt_cnt0=%h pkt_cnt1=%h, required 0000/0000", pkt_cnt0, pkt_cnt1);
        end
        wait_drain("wrap", 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_independence();
        test_reset_mid_packet();
        test_back_to_back();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
